// File: rtl/sound_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sound_sequencer_if : command/piezo bundle between GameLogic and the |
// | sound sequencer.                                       Rev 1.0     |
// +--------------------------------------------------------------------+
interface sound_sequencer_if;
  logic [1:0] sound_cmd;
  logic       mute;
  logic       piezo;
  logic [1:0] level;
  logic       busy;
  logic       drop;

  modport master (output sound_cmd, output mute,
                  input  piezo, input level, input busy, input drop);
  modport slave  (input  sound_cmd, input mute,
                  output piezo, output level, output busy, output drop);
endinterface
`default_nettype wire

// File: rtl/sound_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sound_sequencer : queues hit-sound commands and plays them as       |
// | fixed-length piezo tones separated by silent gaps. Optional         |
// | SND_PREEMPT_EN lets a miss cut short a PERFECT/GOOD tone.           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sound_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TONE_CYC   = 5000000,
  parameter int GAP_CYC    = 1000000,
  parameter int HP_PERFECT = 23877,
  parameter int HP_GOOD    = 31888,
  parameter int HP_MISS    = 127551
) (
  input  logic              clk,
  input  logic              rst,
  sound_sequencer_if.slave  bus
);
  localparam int MAX_A   = (TONE_CYC > GAP_CYC) ? TONE_CYC : GAP_CYC;
  localparam int MAX_B   = (HP_PERFECT > HP_GOOD) ? HP_PERFECT : HP_GOOD;
  localparam int MAX_C   = (MAX_B > HP_MISS) ? MAX_B : HP_MISS;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int NW      = AW + 1;

  localparam logic [CW-1:0] TONE_LAST = CW'(TONE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
  logic [NW-1:0]   count, count_nx;
  logic [CW-1:0]   dur_cnt, dur_cnt_nx, hp_cnt, hp_cnt_nx, hp_last;
  logic            phase, phase_nx;
  logic [1:0]      level, level_nx;
  logic            piezo, piezo_nx, busy, busy_nx, drop, drop_nx;
  logic            push, pop, full, accept, preempt;

  always_comb begin
    full = (count == FULL_CNT);
`ifdef SND_PREEMPT_EN
    preempt = (state == TONE) && (bus.sound_cmd == 2'd3) &&
              ((level == 2'd1) || (level == 2'd2));
`else
    preempt = 1'b0;
`endif
    push    = (bus.sound_cmd != 2'd0) && !preempt;
    // Pop is decided from the registered count only, so a fresh push is never bypassed.
    pop     = (state == IDLE) && (count != '0);
    accept  = push && (!full || pop);
    drop_nx = push && full && !pop;

    case (level)
      2'd1:    hp_last = CW'(HP_PERFECT - 1);
      2'd2:    hp_last = CW'(HP_GOOD - 1);
      default: hp_last = CW'(HP_MISS - 1);
    endcase

    state_nx   = state;
    level_nx   = level;
    dur_cnt_nx = dur_cnt;
    hp_cnt_nx  = hp_cnt;
    phase_nx   = phase;
    wr_ptr_nx  = wr_ptr + AW'(accept);
    rd_ptr_nx  = rd_ptr + AW'(pop);
    count_nx   = count + NW'(accept) - NW'(pop);

    case (state)
      IDLE: begin
        if (pop) begin
          state_nx   = TONE;
          level_nx   = mem[rd_ptr];
          dur_cnt_nx = '0;
          hp_cnt_nx  = '0;
          phase_nx   = 1'b0;
        end
      end
      TONE: begin
        if (preempt) begin
          level_nx   = 2'd3;
          dur_cnt_nx = '0;
          hp_cnt_nx  = '0;
          phase_nx   = 1'b0;
          rd_ptr_nx  = wr_ptr;
          count_nx   = '0;
        end else if (dur_cnt == TONE_LAST) begin
          state_nx   = GAP;
          level_nx   = 2'd0;
          dur_cnt_nx = '0;
          hp_cnt_nx  = '0;
          phase_nx   = 1'b0;
        end else begin
          dur_cnt_nx = dur_cnt + 1'b1;
          if (hp_cnt == hp_last) begin
            hp_cnt_nx = '0;
            phase_nx  = ~phase;
          end else begin
            hp_cnt_nx = hp_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (dur_cnt == GAP_LAST) begin
          state_nx   = IDLE;
          dur_cnt_nx = '0;
        end else begin
          dur_cnt_nx = dur_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    piezo_nx = phase_nx & ~bus.mute & (state_nx == TONE);
    busy_nx  = (state_nx != IDLE) || (count_nx != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dur_cnt <= '0;
      hp_cnt  <= '0;
      phase   <= 1'b0;
      level   <= 2'd0;
      piezo   <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_ptr_nx;
      rd_ptr  <= rd_ptr_nx;
      count   <= count_nx;
      dur_cnt <= dur_cnt_nx;
      hp_cnt  <= hp_cnt_nx;
      phase   <= phase_nx;
      level   <= level_nx;
      piezo   <= piezo_nx;
      busy    <= busy_nx;
      drop    <= drop_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.sound_cmd;
  end

  assign bus.piezo = piezo;
  assign bus.level = level;
  assign bus.busy  = busy;
  assign bus.drop  = drop;
endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sound_sequencer : directed scenarios plus random traffic against |
// | a timeline model of queued tones.                      Rev 1.0     |
// +--------------------------------------------------------------------+
module tb_sound_sequencer;
  localparam int DEPTH = 4;
  localparam int TONE  = 20;
  localparam int GAP   = 4;
`ifdef SND_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk;
  logic rst;
  sound_sequencer_if bus_if();

  sound_sequencer #(
    .FIFO_DEPTH(DEPTH), .TONE_CYC(TONE), .GAP_CYC(GAP),
    .HP_PERFECT(2), .HP_GOOD(3), .HP_MISS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: an active tone/gap is just its level and offset from tone start.
  bit m_active;
  int m_lvl, m_off;
  int q[$];
  int e_piezo, e_level, e_busy, e_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int half_period(input int lvl);
    return (lvl == 1) ? 2 : (lvl == 2) ? 3 : 5;
  endfunction

  task automatic model_update(input int cmd, input bit mute, input bit r);
    bit pre, popq, in_tone;
    int drp;
    drp = 0;
    if (r) begin
      m_active = 0; m_lvl = 0; m_off = 0; q.delete();
    end else begin
      pre  = PRE && m_active && (m_off < TONE) && (cmd == 3) && (m_lvl != 3);
      popq = !m_active && (q.size() > 0);
      if (popq) begin
        m_lvl = q.pop_front(); m_active = 1; m_off = 0;
      end else if (pre) begin
        q.delete(); m_lvl = 3; m_off = 0;
      end else if (m_active) begin
        m_off++;
        if (m_off == TONE + GAP) begin m_active = 0; m_off = 0; end
      end
      if (cmd != 0 && !pre) begin
        if (q.size() < DEPTH) q.push_back(cmd);
        else drp = 1;
      end
    end
    in_tone = m_active && (m_off < TONE);
    e_level = in_tone ? m_lvl : 0;
    e_piezo = (in_tone && !mute && ((m_off / half_period(m_lvl)) % 2 == 1)) ? 1 : 0;
    e_busy  = (m_active || q.size() != 0) ? 1 : 0;
    e_drop  = drp;
  endtask

  // Drive one cycle of inputs, then check the outputs of the following cycle.
  task automatic step(input logic [1:0] cmd, input logic mute, input logic r);
    bus_if.sound_cmd = cmd;
    bus_if.mute      = mute;
    rst              = r;
    model_update(int'(cmd), mute, r);
    @(negedge clk);
    cyc++;
    check_eq("piezo", 32'(bus_if.piezo), 32'(e_piezo));
    check_eq("level", 32'(bus_if.level), 32'(e_level));
    check_eq("busy",  32'(bus_if.busy),  32'(e_busy));
    check_eq("drop",  32'(bus_if.drop),  32'(e_drop));
  endtask

  task automatic idle(input int n, input logic mute);
    for (int i = 0; i < n; i++) step(2'd0, mute, 1'b0);
  endtask

  initial begin
    m_active = 0; m_lvl = 0; m_off = 0;
    rst = 1'b1;
    bus_if.sound_cmd = 2'd0;
    bus_if.mute = 1'b0;

    // Reset held with a command present: nothing may be queued.
    step(2'd3, 1'b0, 1'b1);
    step(2'd3, 1'b0, 1'b1);
    idle(5, 1'b0);

    // Single PERFECT tone.
    step(2'd1, 1'b0, 1'b0);
    idle(30, 1'b0);

    // Overflow: four queued, two dropped.
    step(2'd1, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(2'd2, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    idle(130, 1'b0);

    // Muted GOOD tone.
    step(2'd2, 1'b1, 1'b0);
    idle(30, 1'b1);

    // Miss arriving during a PERFECT tone with two GOODs queued.
    step(2'd1, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(2'd3, 1'b0, 1'b0);
    idle(110, 1'b0);

    // Reset at tone cycle 10 with three commands queued.
    step(2'd1, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    idle(8, 1'b0);
    step(2'd0, 1'b0, 1'b1);
    idle(40, 1'b0);

    // Random traffic with occasional mute changes and rare resets.
    begin
      logic mute_r;
      logic [1:0] c;
      logic r;
      mute_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        c = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
        if ($urandom_range(0, 49) == 0) mute_r = ~mute_r;
        r = ($urandom_range(0, 799) == 0);
        step(c, mute_r, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
